// File: rtl/sweep_sequencer_pkg.sv
// Shared definitions for the sweep sequencer: default widths and FSM state codes.
package sweep_pkg;

  localparam int DEF_W      = 16;
  localparam int DEF_NREV_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_PARK = 2'd3;

endpackage

// File: rtl/sweep_rev_detect.sv
// Watches the bounce counter output and flags each change of counting direction.
// A repeated value (the settle cycle right after a load) is ignored, and the
// very first movement only establishes a direction, so it never counts.
module sweep_rev_detect
  import sweep_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] start_val,
  input  logic [W-1:0] count,
  output logic         rev
);

  logic [W-1:0] prev_count;
  logic         last_up;
  logic         dir_valid;
  logic         moved;
  logic         up;

  assign moved = (count != prev_count);
  assign up    = (count > prev_count);
  assign rev   = enable && moved && dir_valid && (up != last_up);

  // Track the previous sample and the last seen direction; clear re-seeds from the start value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_count <= '0;
      last_up    <= 1'b0;
      dir_valid  <= 1'b0;
    end else if (clear) begin
      prev_count <= start_val;
      dir_valid  <= 1'b0;
    end else if (enable && moved) begin
      prev_count <= count;
      last_up    <= up;
      dir_valid  <= 1'b1;
    end
  end

endmodule

// File: rtl/sweep_sequencer.sv
// Sweep sequencer: accepts a sweep profile, loads it into a free-running bounce
// counter, counts direction reversals and parks the counter when the programmed
// number of reversals is reached or the sweep is aborted.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int NREV_W = DEF_NREV_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [W-1:0]      cfg_start,
  input  logic [W-1:0]      cfg_upper,
  input  logic [W-1:0]      cfg_lower,
  input  logic [NREV_W-1:0] cfg_nrev,
  input  logic [W-1:0]      park_val,
  input  logic              abort,
  output logic [W-1:0]      cnt_data,
  output logic [W-1:0]      cnt_upper,
  output logic [W-1:0]      cnt_lower,
  output logic              cnt_load,
  input  logic [W-1:0]      cnt_count,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              cfg_err,
  output logic [NREV_W-1:0] rev_cnt
);

  state_t            state;
  state_t            next_state;
  logic [NREV_W-1:0] nrev;
  logic              offered;
  logic              accept;
  logic              reject;
  logic              rev;
  logic              final_rev;
  logic              sweeping;
  logic              det_clear;
  logic              det_enable;

  assign offered    = (state == S_IDLE) && start_valid;
  assign accept     = offered && (cfg_lower <= cfg_upper);
  assign reject     = offered && (cfg_lower > cfg_upper);
  assign final_rev  = rev && ((rev_cnt + NREV_W'(1)) == nrev);
  assign sweeping   = (state == S_LOAD) || (state == S_RUN);
  assign det_clear  = (state == S_LOAD);
  assign det_enable = (state == S_RUN);

  // The detector is re-seeded from cnt_data, which holds the captured start value during LOAD.
  sweep_rev_detect #(.W(W)) u_rev_detect (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (det_clear),
    .enable    (det_enable),
    .start_val (cnt_data),
    .count     (cnt_count),
    .rev       (rev)
  );

  // Next-state decision; abort wins over normal progress in LOAD and RUN.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_LOAD;
      S_LOAD:  next_state = (abort || (nrev == '0)) ? S_PARK : S_RUN;
      S_RUN:   if (abort || final_rev) next_state = S_PARK;
      S_PARK:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State and status flags are registered from the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      cnt_load    <= 1'b1;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= next_state;
      start_ready <= (next_state == S_IDLE);
      busy        <= (next_state != S_IDLE);
      cnt_load    <= (next_state != S_RUN);
      done        <= (next_state == S_PARK);
      aborted     <= sweeping && abort;
      cfg_err     <= reject;
    end
  end

  // Counter data: park value while idle or parking, start value for the load cycle, don't-care in RUN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_data <= '0;
    end else begin
      case (next_state)
        S_LOAD:  cnt_data <= cfg_start;
        S_RUN:   cnt_data <= cnt_data;
        default: cnt_data <= park_val;
      endcase
    end
  end

  // Profile capture on an accepted handshake, plus the reversal count for the running sweep.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_upper <= '1;
      cnt_lower <= '0;
      nrev      <= '0;
      rev_cnt   <= '0;
    end else if (accept) begin
      cnt_upper <= cfg_upper;
      cnt_lower <= cfg_lower;
      nrev      <= cfg_nrev;
      rev_cnt   <= '0;
    end else if (det_enable && rev) begin
      rev_cnt   <= rev_cnt + NREV_W'(1);
    end
  end

endmodule
